// File: rtl/afifo_pkg.sv
// Shared constants and occupancy encoding for the afifo read-side stream stage.
package afifo_pkg;
   localparam int DSIZE_DEF = 8;
   localparam int ASIZE_DEF = 4;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;
endpackage

// File: rtl/afifo_rd_skid.sv
// Two-entry head/tail holding buffer with occupancy tracking.
// Captured words land in head when it is free (or being popped), else in tail.
module afifo_rd_skid
   import afifo_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             cap,
   input  logic [DSIZE-1:0] cap_data,
   input  logic             pop,
   output occ_t             occ,
   output logic [DSIZE-1:0] head
);

   logic [DSIZE-1:0] tail;
   occ_t             occ_nxt;

   always_comb begin
      occ_nxt = occ;
      if (cap && !pop)
         occ_nxt = occ_t'(occ + 2'd1);
      else if (!cap && pop)
         occ_nxt = occ_t'(occ - 2'd1);
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         occ  <= OCC_EMPTY;
         head <= '0;
         tail <= '0;
      end else begin
         occ <= occ_nxt;
         if (cap && (occ == OCC_EMPTY || (occ == OCC_ONE && pop)))
            head <= cap_data;
         else if (pop && occ == OCC_TWO)
            head <= tail;
         if (cap && occ == OCC_ONE && !pop)
            tail <= cap_data;
      end
   end

`ifndef SYNTHESIS
   // The issue rule upstream must never let a word arrive with both slots full.
   always_ff @(posedge rclk) begin
      if (!rrst && cap)
         assert (occ != OCC_TWO) else $error("afifo_rd_skid: capture into full buffer");
   end
`endif

endmodule

// File: rtl/afifo_rd_stream.sv
// afifo pop interface (1-cycle read latency) to valid/ready stream with 2-word prefetch.
// Optional AFIFO_RD_STATS_EN adds saturating word_cnt / stall_cnt outputs.
module afifo_rd_stream
   import afifo_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rden,
   output logic             m_valid,
   output logic [DSIZE-1:0] m_data,
   input  logic             m_ready
`ifdef AFIFO_RD_STATS_EN
   ,
   output logic [31:0]      word_cnt,
   output logic [31:0]      stall_cnt
`endif
);

   occ_t       occ;
   logic       inflight;
   logic       pop;
   logic [2:0] pending;

   assign m_valid = (occ != OCC_EMPTY);
   assign pop     = m_valid && m_ready;

   // Words held or arriving after this edge; a new pop may only be issued if a slot remains.
   assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign rden    = !rrst && !rempty && (pending < 3'd2);

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst)
         inflight <= 1'b0;
      else
         inflight <= rden;
   end

   afifo_rd_skid #(.DSIZE(DSIZE)) u_skid (
      .rclk     (rclk),
      .rrst     (rrst),
      .cap      (inflight),
      .cap_data (rdata),
      .pop      (pop),
      .occ      (occ),
      .head     (m_data)
   );

`ifdef AFIFO_RD_STATS_EN
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         word_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (pop && word_cnt != '1)
            word_cnt <= word_cnt + 32'd1;
         if (m_valid && !m_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
